// File: rtl/imem_fetch_responder.sv
// ---------------------------------------------------------------------------
// imem_fetch_responder
//
// Responder side of the PC -> instruction-memory fetch path. It takes one
// fetch address per req_valid/req_ready handshake and issues a one-cycle read
// strobe to a fixed-latency backing memory. When the data is due, it captures
// the word and presents it to decode with its address over a
// resp_valid/resp_ready handshake. A branch redirect (flush) drops any
// pending or presented fetch. A delivered instruction whose top nibble is 4'hF
// latches the sticky halted flag.
//
// Ports
//   clk, rst      clock; asynchronous active-low reset (0 = reset)
//   req_valid     PC stage presents req_addr
//   req_addr      fetch address (bit 0 ignored, halfword aligned)
//   req_ready     a request can be accepted this cycle
//   flush         branch redirect: discard in-flight / presented fetch
//   resp_valid    resp_instr / resp_addr are valid
//   resp_instr    fetched instruction
//   resp_addr     address the instruction came from
//   resp_ready    decode consumes the response
//   mem_en        one-cycle read strobe to backing memory
//   mem_addr      read address, stable until the data is captured
//   mem_rdata     memory data, sampled WAIT_CYCLES cycles after mem_en
//   halted        sticky, set when a halt instruction is consumed
// ---------------------------------------------------------------------------
module imem_fetch_responder #(
  parameter int ADDR_W      = 16,
  parameter int DATA_W      = 16,
  parameter int WAIT_CYCLES = 3
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req_valid,
  input  logic [ADDR_W-1:0] req_addr,
  output logic              req_ready,
  input  logic              flush,
  output logic              resp_valid,
  output logic [DATA_W-1:0] resp_instr,
  output logic [ADDR_W-1:0] resp_addr,
  input  logic              resp_ready,
  output logic              mem_en,
  output logic [ADDR_W-1:0] mem_addr,
  input  logic [DATA_W-1:0] mem_rdata,
  output logic              halted
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_WAIT = 2'd1,
    S_RESP = 2'd2
  } state_t;

  localparam logic [3:0] CNT_INIT = 4'(WAIT_CYCLES);

  state_t              state_q, state_d;
  logic [3:0]          cnt_q, cnt_d;
  logic                discard_q, discard_d;
  logic                halted_q, halted_d;
  logic [DATA_W-1:0]   resp_instr_q, resp_instr_d;
  logic [ADDR_W-1:0]   resp_addr_q, resp_addr_d;
  logic                mem_en_q, mem_en_d;
  logic [ADDR_W-1:0]   mem_addr_q, mem_addr_d;

  logic accept;
  logic is_halt_op;
  logic unused_addr_lsb;

  // Fetches are halfword aligned; the low address bit never reaches memory.
  assign unused_addr_lsb = req_addr[0];

  assign req_ready  = !halted_q && !flush &&
                      ((state_q == S_IDLE) || ((state_q == S_RESP) && resp_ready));
  assign accept     = req_valid && req_ready;
  assign is_halt_op = (resp_instr_q[DATA_W-1 -: 4] == 4'hF);

  always_comb begin
    state_d      = state_q;
    cnt_d        = cnt_q;
    discard_d    = discard_q;
    halted_d     = halted_q;
    resp_instr_d = resp_instr_q;
    resp_addr_d  = resp_addr_q;
    mem_en_d     = 1'b0;
    mem_addr_d   = mem_addr_q;

    case (state_q)
      S_IDLE: begin
        if (accept) begin
          state_d = S_WAIT;
        end
      end

      S_WAIT: begin
        // The memory read always runs to completion, even after a flush,
        // so the backing memory never sees an abandoned transaction.
        cnt_d = cnt_q - 4'd1;
        if (flush) begin
          discard_d = 1'b1;
        end
        if (cnt_q == 4'd1) begin
          discard_d = 1'b0;
          if (discard_q || flush) begin
            state_d = S_IDLE;
          end else begin
            resp_instr_d = mem_rdata;
            resp_addr_d  = mem_addr_q;
            state_d      = S_RESP;
          end
        end
      end

      S_RESP: begin
        if (flush) begin
          // A flushed response is never consumed, so it cannot halt.
          state_d = S_IDLE;
        end else if (resp_ready) begin
          if (is_halt_op) begin
            halted_d = 1'b1;
          end
          state_d = accept ? S_WAIT : S_IDLE;
        end
      end

      default: begin
        state_d = S_IDLE;
      end
    endcase

    // Issue of a new fetch is common to IDLE and RESP.
    if (accept) begin
      mem_en_d   = 1'b1;
      mem_addr_d = {req_addr[ADDR_W-1:1], 1'b0};
      cnt_d      = CNT_INIT;
      discard_d  = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q      <= S_IDLE;
      cnt_q        <= 4'd0;
      discard_q    <= 1'b0;
      halted_q     <= 1'b0;
      resp_instr_q <= '0;
      resp_addr_q  <= '0;
      mem_en_q     <= 1'b0;
      mem_addr_q   <= '0;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      discard_q    <= discard_d;
      halted_q     <= halted_d;
      resp_instr_q <= resp_instr_d;
      resp_addr_q  <= resp_addr_d;
      mem_en_q     <= mem_en_d;
      mem_addr_q   <= mem_addr_d;
    end
  end

  assign resp_valid = (state_q == S_RESP);
  assign resp_instr = resp_instr_q;
  assign resp_addr  = resp_addr_q;
  assign mem_en     = mem_en_q;
  assign mem_addr   = mem_addr_q;
  assign halted     = halted_q;

endmodule
